// File: rtl/id_ex_stage_ctrl.sv
// ID stage controller: decodes the IF/ID instruction, drives the immediate extender select,
// captures decoded controls into the ID/EX register and inserts load-use / flush bubbles.
module id_ex_stage_ctrl #(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [31:0]            Instr,
   input  logic                   IfIdValid,
   input  logic [31:0]            ExtImm,
   input  logic                   BranchTaken,
   input  logic                   MemBusy,
   output logic                   ExtendType,
   output logic                   Stall,
   output logic                   IdExValid,
   output logic                   IdExRegWrite,
   output logic                   IdExMemRead,
   output logic                   IdExMemWrite,
   output logic                   IdExALUSrc,
   output logic                   IdExRegDst,
   output logic                   IdExBranch,
   output logic [4:0]             IdExRs,
   output logic [4:0]             IdExRt,
   output logic [4:0]             IdExRd,
   output logic [31:0]            IdExImm,
   output logic                   IllegalOp,
   output logic [STALL_CNT_W-1:0] StallCount
);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   // Instruction fields
   logic [5:0] op;
   logic [4:0] instr_rs;
   logic [4:0] instr_rt;
   logic [4:0] instr_rd;
   logic       unused_instr;

   assign op           = Instr[31:26];
   assign instr_rs     = Instr[25:21];
   assign instr_rt     = Instr[20:16];
   assign instr_rd     = Instr[15:11];
   // Low immediate bits reach the datapath through ExtImm, not through this block.
   assign unused_instr = ^Instr[10:0];

   // Decoded controls
   logic dec_reg_write;
   logic dec_mem_read;
   logic dec_mem_write;
   logic dec_alu_src;
   logic dec_reg_dst;
   logic dec_branch;
   logic dec_ext;
   logic dec_rt_used;
   logic dec_illegal;

   // ID/EX register state
   logic                   valid_q,     valid_d;
   logic                   reg_write_q, reg_write_d;
   logic                   mem_read_q,  mem_read_d;
   logic                   mem_write_q, mem_write_d;
   logic                   alu_src_q,   alu_src_d;
   logic                   reg_dst_q,   reg_dst_d;
   logic                   branch_q,    branch_d;
   logic                   illegal_q,   illegal_d;
   logic [4:0]             rs_q,        rs_d;
   logic [4:0]             rt_q,        rt_d;
   logic [4:0]             rd_q,        rd_d;
   logic [31:0]            imm_q,       imm_d;
   logic [STALL_CNT_W-1:0] cnt_q,       cnt_d;

   logic hazard;
   logic cnt_sat;

   // Opcode decode; unknown opcodes decode to all-zero controls and flag illegal
   always_comb begin
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_alu_src   = 1'b0;
      dec_reg_dst   = 1'b0;
      dec_branch    = 1'b0;
      dec_ext       = 1'b0;
      dec_rt_used   = 1'b0;
      dec_illegal   = 1'b0;
      case (op)
         OpRtype: begin
            dec_reg_write = 1'b1;
            dec_reg_dst   = 1'b1;
            dec_rt_used   = 1'b1;
         end
         OpAddi, OpAddiu, OpSlti: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_ext       = 1'b1;
         end
         OpAndi, OpOri, OpXori, OpLui: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
         end
         OpLw: begin
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
            dec_alu_src   = 1'b1;
            dec_ext       = 1'b1;
         end
         OpSw: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_ext       = 1'b1;
            dec_rt_used   = 1'b1;
         end
         OpBeq, OpBne: begin
            dec_branch    = 1'b1;
            dec_ext       = 1'b1;
            dec_rt_used   = 1'b1;
         end
         default: begin
            dec_illegal   = 1'b1;
         end
      endcase
   end

   // Load-use detection against the load currently sitting in ID/EX; $zero never conflicts
   always_comb begin
      hazard = valid_q & mem_read_q & (rt_q != 5'd0) & IfIdValid &
               ((rt_q == instr_rs) | (dec_rt_used & (rt_q == instr_rt)));
   end

   assign ExtendType = dec_ext;
   // A flush or a frozen pipeline makes the stall moot
   assign Stall      = hazard & ~BranchTaken & ~MemBusy;
   assign cnt_sat    = &cnt_q;

   // Next ID/EX contents: freeze, flush bubble, load-use bubble, or normal capture
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      alu_src_d   = alu_src_q;
      reg_dst_d   = reg_dst_q;
      branch_d    = branch_q;
      illegal_d   = illegal_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      cnt_d       = cnt_q;
      if (MemBusy) begin
         // Whole pipeline frozen; a pending branch is re-asserted by the branch unit.
      end else if (BranchTaken || hazard) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         alu_src_d   = 1'b0;
         reg_dst_d   = 1'b0;
         branch_d    = 1'b0;
         illegal_d   = 1'b0;
         // Fields are don't-care under a bubble; loading them keeps the mux simple.
         rs_d        = instr_rs;
         rt_d        = instr_rt;
         rd_d        = instr_rd;
         imm_d       = ExtImm;
         // Only load-use bubbles are counted, not flushes
         if (!BranchTaken && !cnt_sat) begin
            cnt_d = cnt_q + CntOne;
         end
      end else begin
         valid_d     = IfIdValid;
         reg_write_d = dec_reg_write & IfIdValid;
         mem_read_d  = dec_mem_read  & IfIdValid;
         mem_write_d = dec_mem_write & IfIdValid;
         alu_src_d   = dec_alu_src   & IfIdValid;
         reg_dst_d   = dec_reg_dst   & IfIdValid;
         branch_d    = dec_branch    & IfIdValid;
         illegal_d   = dec_illegal   & IfIdValid;
         rs_d        = instr_rs;
         rt_d        = instr_rt;
         rd_d        = instr_rd;
         imm_d       = ExtImm;
      end
   end

   // ID/EX pipeline register with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         alu_src_q   <= 1'b0;
         reg_dst_q   <= 1'b0;
         branch_q    <= 1'b0;
         illegal_q   <= 1'b0;
         rs_q        <= 5'd0;
         rt_q        <= 5'd0;
         rd_q        <= 5'd0;
         imm_q       <= 32'd0;
         cnt_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         alu_src_q   <= alu_src_d;
         reg_dst_q   <= reg_dst_d;
         branch_q    <= branch_d;
         illegal_q   <= illegal_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         cnt_q       <= cnt_d;
      end
   end

   assign IdExValid    = valid_q;
   assign IdExRegWrite = reg_write_q;
   assign IdExMemRead  = mem_read_q;
   assign IdExMemWrite = mem_write_q;
   assign IdExALUSrc   = alu_src_q;
   assign IdExRegDst   = reg_dst_q;
   assign IdExBranch   = branch_q;
   assign IdExRs       = rs_q;
   assign IdExRt       = rt_q;
   assign IdExRd       = rd_q;
   assign IdExImm      = imm_q;
   assign IllegalOp    = illegal_q;
   assign StallCount   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_ctrl.sv
// Bench for id_ex_stage_ctrl: directed scenarios plus randomized traffic against a
// table-driven reference model.
module tb_id_ex_stage_ctrl;

   // Narrow counter so saturation is reachable in a short run
   localparam int unsigned CW = 6;
   localparam int unsigned CntMax = (1 << CW) - 1;

   // Expected {valid, regwrite, memread, memwrite, alusrc, regdst, branch, illegal}
   localparam logic [7:0] CtlLw   = 8'b1110_1000;
   localparam logic [7:0] CtlAndi = 8'b1100_1000;
   localparam logic [7:0] CtlAdd  = 8'b1100_0100;
   localparam logic [7:0] CtlIll  = 8'b1000_0001;
   localparam logic [7:0] CtlNone = 8'b0000_0000;

   localparam logic [31:0] InstrLw   = 32'h8C22_0004;  // lw  $2,4($1)
   localparam logic [31:0] InstrAdd  = 32'h0042_1820;  // add $3,$2,$2
   localparam logic [31:0] InstrAndi = 32'h3004_FFFF;  // andi $4,$0,0xFFFF
   localparam logic [31:0] InstrIll  = 32'hFC00_0000;
   localparam logic [31:0] InstrLwSelf = 32'h8C42_0000;  // lw $2,0($2)

   logic          Clk = 1'b0;
   logic          Reset;
   logic [31:0]   Instr;
   logic          IfIdValid;
   logic [31:0]   ExtImm;
   logic          BranchTaken;
   logic          MemBusy;
   logic          ExtendType;
   logic          Stall;
   logic          IdExValid;
   logic          IdExRegWrite, IdExMemRead, IdExMemWrite, IdExALUSrc, IdExRegDst, IdExBranch;
   logic [4:0]    IdExRs, IdExRt, IdExRd;
   logic [31:0]   IdExImm;
   logic          IllegalOp;
   logic [CW-1:0] StallCount;

   int checks = 0;
   int errors = 0;

   logic [7:0] ctl_obs;
   assign ctl_obs = {IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite,
                     IdExALUSrc, IdExRegDst, IdExBranch, IllegalOp};

   id_ex_stage_ctrl #(
      .STALL_CNT_W(CW)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Instr       (Instr),
      .IfIdValid   (IfIdValid),
      .ExtImm      (ExtImm),
      .BranchTaken (BranchTaken),
      .MemBusy     (MemBusy),
      .ExtendType  (ExtendType),
      .Stall       (Stall),
      .IdExValid   (IdExValid),
      .IdExRegWrite(IdExRegWrite),
      .IdExMemRead (IdExMemRead),
      .IdExMemWrite(IdExMemWrite),
      .IdExALUSrc  (IdExALUSrc),
      .IdExRegDst  (IdExRegDst),
      .IdExBranch  (IdExBranch),
      .IdExRs      (IdExRs),
      .IdExRt      (IdExRt),
      .IdExRd      (IdExRd),
      .IdExImm     (IdExImm),
      .IllegalOp   (IllegalOp),
      .StallCount  (StallCount)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [5:0] ctl;    // RegWrite/MemRead/MemWrite/ALUSrc/RegDst/Branch
      logic       ext;
      logic       rtu;
      logic       ill;
   } dec_t;

   typedef struct packed {
      logic        valid;
      logic [5:0]  ctl;
      logic        ill;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] imm;
   } idex_t;

   idex_t       m;
   int unsigned mcnt;

   function automatic dec_t ref_decode(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         6'b000000:                       begin d.ctl = 6'b100010; d.rtu = 1'b1; end
         6'b001000, 6'b001001, 6'b001010: begin d.ctl = 6'b100100; d.ext = 1'b1; end
         6'b001100, 6'b001101,
         6'b001110, 6'b001111:            begin d.ctl = 6'b100100; end
         6'b100011:                       begin d.ctl = 6'b110100; d.ext = 1'b1; end
         6'b101011:                       begin d.ctl = 6'b001100; d.ext = 1'b1; d.rtu = 1'b1; end
         6'b000100, 6'b000101:            begin d.ctl = 6'b000001; d.ext = 1'b1; d.rtu = 1'b1; end
         default:                         d.ill = 1'b1;
      endcase
      return d;
   endfunction

   function automatic logic ref_hazard();
      dec_t d;
      d = ref_decode(Instr[31:26]);
      return m.valid && m.ctl[4] && (m.rt != 5'd0) && IfIdValid &&
             ((m.rt == Instr[25:21]) || (d.rtu && (m.rt == Instr[20:16])));
   endfunction

   // Advance the model by one clock using the inputs currently applied
   task automatic ref_clock();
      dec_t d;
      logic haz;
      d   = ref_decode(Instr[31:26]);
      haz = ref_hazard();
      if (Reset) begin
         m    = '0;
         mcnt = 0;
      end else if (MemBusy) begin
         m = m;
      end else if (BranchTaken || haz) begin
         m.valid = 1'b0;
         m.ctl   = '0;
         m.ill   = 1'b0;
         if (!BranchTaken && mcnt < CntMax) mcnt = mcnt + 1;
      end else begin
         m.valid = IfIdValid;
         m.ctl   = IfIdValid ? d.ctl : 6'b0;
         m.ill   = IfIdValid & d.ill;
         m.rs    = Instr[25:21];
         m.rt    = Instr[20:16];
         m.rd    = Instr[15:11];
         m.imm   = ExtImm;
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset       = 1'b1;
      BranchTaken = 1'b0;
      MemBusy     = 1'b0;
      tick();
      Reset = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      Reset = 1'b1; Instr = InstrLw; IfIdValid = 1'b1; ExtImm = 32'd4;
      BranchTaken = 1'b0; MemBusy = 1'b0;
      tick();
      tick();
      checks++;
      if (ctl_obs !== CtlNone || IdExRs !== 5'd0 || IdExRt !== 5'd0 || IdExRd !== 5'd0) begin
         errors++;
         $display("FAIL reset_regs: got ctl=%b rs=%0d rt=%0d rd=%0d required all 0",
                  ctl_obs, IdExRs, IdExRt, IdExRd);
      end
      checks++;
      if (IdExImm !== 32'd0 || StallCount !== '0 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_misc: got imm=%h cnt=%0d stall=%b required 0", IdExImm,
                  StallCount, Stall);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (Stall !== 1'b0 || ExtendType !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_comb: got stall=%b ext=%b required 0/1", Stall, ExtendType);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlLw || IdExRs !== 5'd1 || IdExRt !== 5'd2 || IdExImm !== 32'd4) begin
         errors++;
         $display("FAIL reset_first_capture: got ctl=%b rs=%0d rt=%0d imm=%h required %b 1 2 4",
                  ctl_obs, IdExRs, IdExRt, IdExImm, CtlLw);
      end
   endtask

   task automatic test_andi();
      Instr = InstrAndi; ExtImm = 32'h0000_FFFF;
      #1;
      checks++;
      if (ExtendType !== 1'b0 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL andi_comb: got ext=%b stall=%b required 0/0", ExtendType, Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlAndi || IdExImm !== 32'h0000_FFFF || IdExRt !== 5'd4) begin
         errors++;
         $display("FAIL andi_capture: got ctl=%b imm=%h rt=%0d required %b 0000ffff 4",
                  ctl_obs, IdExImm, IdExRt, CtlAndi);
      end
   endtask

   task automatic test_load_use();
      Instr = InstrLw; ExtImm = 32'd4;
      #1;
      tick();
      Instr = InstrAdd; ExtImm = 32'h0000_1820;
      #1;
      checks++;
      if (Stall !== 1'b1 || ExtendType !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_stall: got stall=%b ext=%b required 1/0", Stall, ExtendType);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlNone || StallCount !== CW'(1)) begin
         errors++;
         $display("FAIL loaduse_bubble: got ctl=%b cnt=%0d required %b 1", ctl_obs, StallCount,
                  CtlNone);
      end
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_stall_once: got stall=%b required 0", Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlAdd || IdExRd !== 5'd3 || StallCount !== CW'(1)) begin
         errors++;
         $display("FAIL loaduse_add: got ctl=%b rd=%0d cnt=%0d required %b 3 1", ctl_obs,
                  IdExRd, StallCount, CtlAdd);
      end
   endtask

   task automatic test_branch_flush();
      do_reset();
      Instr = InstrLw; ExtImm = 32'd4;
      tick();
      Instr = InstrAdd; ExtImm = 32'h0000_1820; BranchTaken = 1'b1;
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall: got stall=%b required 0", Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlNone || StallCount !== '0) begin
         errors++;
         $display("FAIL flush_bubble: got ctl=%b cnt=%0d required %b 0", ctl_obs, StallCount,
                  CtlNone);
      end
      BranchTaken = 1'b0;
      tick();
      checks++;
      if (ctl_obs !== CtlAdd) begin
         errors++;
         $display("FAIL flush_next: got ctl=%b required %b", ctl_obs, CtlAdd);
      end
   endtask

   task automatic test_membusy();
      do_reset();
      Instr = InstrLw; ExtImm = 32'd4;
      tick();
      Instr = InstrAdd; ExtImm = 32'h0000_1820; MemBusy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL busy_stall[%0d]: got stall=%b required 0", i, Stall);
         end
         tick();
         checks++;
         if (ctl_obs !== CtlLw || IdExImm !== 32'd4 || IdExRt !== 5'd2 || StallCount !== '0) begin
            errors++;
            $display("FAIL busy_freeze[%0d]: got ctl=%b imm=%h rt=%0d cnt=%0d required %b 4 2 0",
                     i, ctl_obs, IdExImm, IdExRt, StallCount, CtlLw);
         end
      end
      MemBusy = 1'b0;
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL busy_release_stall: got stall=%b required 1", Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlNone || StallCount !== CW'(1) || Stall !== 1'b0) begin
         errors++;
         $display("FAIL busy_release_bubble: got ctl=%b cnt=%0d stall=%b required 0 1 0",
                  ctl_obs, StallCount, Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlAdd) begin
         errors++;
         $display("FAIL busy_release_add: got ctl=%b required %b", ctl_obs, CtlAdd);
      end
   endtask

   task automatic test_illegal();
      Instr = InstrIll; ExtImm = 32'd0;
      #1;
      checks++;
      if (ExtendType !== 1'b0 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL illegal_comb: got ext=%b stall=%b required 0/0", ExtendType, Stall);
      end
      tick();
      checks++;
      if (ctl_obs !== CtlIll) begin
         errors++;
         $display("FAIL illegal_capture: got ctl=%b required %b", ctl_obs, CtlIll);
      end
      IfIdValid = 1'b0;
      tick();
      checks++;
      if (ctl_obs !== CtlNone) begin
         errors++;
         $display("FAIL illegal_invalid_slot: got ctl=%b required %b", ctl_obs, CtlNone);
      end
      IfIdValid = 1'b1;
   endtask

   // lw $2,0($2) held in IF/ID hazards against itself on every second cycle
   task automatic test_saturation();
      int unsigned exp;
      do_reset();
      Instr = InstrLwSelf; ExtImm = 32'd0;
      for (int k = 1; k <= int'(CntMax) + 3; k++) begin
         tick();
         tick();
         exp = (k > int'(CntMax)) ? CntMax : k;
         checks++;
         if (StallCount !== CW'(exp)) begin
            errors++;
            $display("FAIL sat_count[%0d]: got %0d required %0d", k, StallCount, exp);
         end
      end
   endtask

   // ---------------- randomized traffic ----------------
   task automatic test_random(input int n);
      logic [5:0] ops [15];
      logic       exp_stall;
      dec_t       d;
      ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
              6'h23, 6'h2B, 6'h04, 6'h05, 6'h23, 6'h23, 6'h3F};
      do_reset();
      m    = '0;
      mcnt = 0;
      for (int i = 0; i < n; i++) begin
         Instr[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 14)];
         Instr[25:21] = 5'($urandom_range(0, 3));
         Instr[20:16] = 5'($urandom_range(0, 3));
         Instr[15:0]  = 16'($urandom);
         ExtImm       = $urandom;
         IfIdValid    = ($urandom_range(0, 9) != 0);
         BranchTaken  = ($urandom_range(0, 9) == 0);
         MemBusy      = ($urandom_range(0, 6) == 0);
         Reset        = ($urandom_range(0, 99) < 2);
         #1;
         d         = ref_decode(Instr[31:26]);
         exp_stall = ref_hazard() && !BranchTaken && !MemBusy;
         checks++;
         if (Stall !== exp_stall || ExtendType !== d.ext) begin
            errors++;
            $display("FAIL rnd_comb[%0d]: got stall=%b ext=%b required %b %b", i, Stall,
                     ExtendType, exp_stall, d.ext);
         end
         ref_clock();
         tick();
         checks++;
         if (ctl_obs !== {m.valid, m.ctl, m.ill} || StallCount !== CW'(mcnt)) begin
            errors++;
            $display("FAIL rnd_regs[%0d]: got ctl=%b cnt=%0d required %b %0d", i, ctl_obs,
                     StallCount, {m.valid, m.ctl, m.ill}, mcnt);
         end
         if (m.valid) begin
            checks++;
            if (IdExRs !== m.rs || IdExRt !== m.rt || IdExRd !== m.rd || IdExImm !== m.imm) begin
               errors++;
               $display("FAIL rnd_fields[%0d]: got %0d %0d %0d %h required %0d %0d %0d %h", i,
                        IdExRs, IdExRt, IdExRd, IdExImm, m.rs, m.rt, m.rd, m.imm);
            end
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_andi();
      test_load_use();
      test_branch_flush();
      test_membusy();
      test_illegal();
      test_saturation();
      test_random(2000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_ctrl.md
Name: id_ex_stage_ctrl

Overview:
- Decode-stage controller for the pipelined CPU.
- Decodes the IF/ID instruction and drives ExtendType combinationally to the immediate extender.
- Captures the extended immediate and the decoded control fields into the ID/EX pipeline register.
- Detects load-use hazards against its own ID/EX contents and sequences stalls, bubbles and flushes.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-event counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Instr  input  32  IF/ID instruction word.
- IfIdValid  input  1  IF/ID holds a real instruction.
- ExtImm  input  32  extender result for Instr[15:0].
- BranchTaken  input  1  branch resolved taken; flush the ID instruction.
- MemBusy  input  1  data memory not ready; freeze the whole pipeline.
- ExtendType  output  1  to extender: 1 = sign-extend, 0 = zero-extend (combinational).
- Stall  output  1  hold PC and IF/ID this cycle (combinational).
- IdExValid  output  1  registered valid bit of ID/EX.
- IdExRegWrite, IdExMemRead, IdExMemWrite, IdExALUSrc, IdExRegDst, IdExBranch  output  1 each  registered controls.
- IdExRs, IdExRt, IdExRd  output  5 each  registered register fields.
- IdExImm  output  32  registered ExtImm.
- IllegalOp  output  1  registered; set when the captured opcode is undecodable.
- StallCount  output  STALL_CNT_W  saturating count of load-use bubbles.

Behaviour:
- Decode on Op = Instr[31:26] (RegWrite/MemRead/MemWrite/ALUSrc/RegDst/Branch, ExtendType, rt-used):
  - 000000 R-type: 1/0/0/0/1/0, ext 0, rt used.
  - 001000 addi, 001001 addiu, 001010 slti: 1/0/0/1/0/0, ext 1.
  - 001100 andi, 001101 ori, 001110 xori, 001111 lui: 1/0/0/1/0/0, ext 0.
  - 100011 lw: 1/1/0/1/0/0, ext 1.
  - 101011 sw: 0/0/1/1/0/0, ext 1, rt used.
  - 000100 beq, 000101 bne: 0/0/0/0/0/1, ext 1, rt used.
  - Any other opcode: all controls 0, ext 0, IllegalOp captured as 1.
- ExtendType is a pure function of Instr and does not depend on IfIdValid.
- Hazard = IdExValid & IdExMemRead & (IdExRt != 0) & IfIdValid & ((IdExRt == Instr[25:21]) | (rt-used & IdExRt == Instr[20:16])).
- Stall = Hazard & ~BranchTaken & ~MemBusy.
- Register update on each rising Clk, in priority order:
  1. Reset: IdExValid, all IdEx controls, IdExRs/Rt/Rd, IdExImm, IllegalOp, StallCount = 0. Stall reads 0 the cycle after Reset deasserts, because IdExValid = 0. Reset mid-stall discards the bubble and the pending instruction.
  2. MemBusy: all ID/EX registers and StallCount hold. No bubble, no flush. BranchTaken is ignored that cycle; the branch unit re-asserts it.
  3. BranchTaken: bubble. IdExValid = 0, all controls and IllegalOp = 0. Field and Imm registers may load but are don't-care.
  4. Hazard: bubble as above. StallCount += 1, saturating at all-ones (no wrap). Instr is re-presented next cycle, so the stall lasts exactly one cycle per load.
  5. Otherwise: IdExValid = IfIdValid. Controls and IllegalOp load from decode gated by IfIdValid, so an invalid slot gives a zero bubble. Rs = Instr[25:21], Rt = Instr[20:16], Rd = Instr[15:11], IdExImm = ExtImm.
- Latency: one cycle from IF/ID to ID/EX outputs. Stall and ExtendType are same-cycle.
- IdExRt = 0 never triggers a hazard, since $zero is never a real load destination.
- Back-to-back loads with a dependent chain stall once per dependent pair.

Test Plan:
- Reset held for 2 cycles with Instr = lw: all outputs 0 and Stall = 0. First edge after release gives IdExValid = 1, IdExMemRead = 1, IdExALUSrc = 1.
- Instr = 0x3004FFFF (andi, imm FFFF): ExtendType = 0. Drive ExtImm = 0x0000FFFF -> next cycle IdExImm = 0x0000FFFF, IdExALUSrc = 1, IdExRegDst = 0.
- Instr = 0x8C220004 (lw $2,4($1)), then 0x00421820 (add $3,$2,$2):
  - Cycle 2: Stall = 1, then a bubble with IdExValid = 0, StallCount = 1.
  - Cycle 3: Stall = 0, add captured with IdExRegDst = 1.
- lw $2 followed by add with BranchTaken = 1 in the same cycle: Stall = 0, bubble inserted, StallCount stays 0.
- lw $2 followed by a dependent add with MemBusy = 1 for 3 cycles: all ID/EX outputs frozen at the lw values and Stall = 0. After MemBusy drops: Stall = 1 for exactly 1 cycle.
- Instr = 0xFC000000: IllegalOp = 1, all controls 0. Force StallCount to the 0xFFFF case via repeated hazards -> it stays 0xFFFF.
